// File: rtl/rv32v_mem_lane_serializer_if.sv
// Bundle of execute-side beat, data-memory and writeback signals for the
// two-lane vector memory serializer. The slave modport is the serializer's
// view; the master modport is the view of whatever surrounds it.
interface rv32v_mem_lane_serializer_if #(
  parameter int OFFSET_W = 5
);
  // execute beat
  logic                ena;
  logic                load_ena;
  logic                store_ena;
  logic [1:0]          wen;
  logic [31:0]         aluresult0;
  logic [31:0]         aluresult1;
  logic [31:0]         storedata0;
  logic [31:0]         storedata1;
  logic [1:0]          eew;
  logic [4:0]          vd;
  logic [OFFSET_W-1:0] woffset0;
  logic [OFFSET_W-1:0] woffset1;
  logic                stall;

  // single-ported data memory
  logic [31:0]         dmem_addr;
  logic                dmem_ren;
  logic                dmem_wen;
  logic [31:0]         dmem_wdata;
  logic [3:0]          dmem_byte_en;
  logic [31:0]         dmem_rdata;
  logic                dmem_busy;

  // vector writeback
  logic                wb_valid;
  logic [1:0]          wb_wen;
  logic [31:0]         wb_data0;
  logic [31:0]         wb_data1;
  logic [OFFSET_W-1:0] wb_offset0;
  logic [OFFSET_W-1:0] wb_offset1;
  logic [4:0]          wb_vd;
  logic                misaligned;

  modport slave (
    input  ena, load_ena, store_ena, wen, aluresult0, aluresult1,
           storedata0, storedata1, eew, vd, woffset0, woffset1,
           dmem_rdata, dmem_busy,
    output stall, dmem_addr, dmem_ren, dmem_wen, dmem_wdata, dmem_byte_en,
           wb_valid, wb_wen, wb_data0, wb_data1, wb_offset0, wb_offset1,
           wb_vd, misaligned
  );

  modport master (
    output ena, load_ena, store_ena, wen, aluresult0, aluresult1,
           storedata0, storedata1, eew, vd, woffset0, woffset1,
           dmem_rdata, dmem_busy,
    input  stall, dmem_addr, dmem_ren, dmem_wen, dmem_wdata, dmem_byte_en,
           wb_valid, wb_wen, wb_data0, wb_data1, wb_offset0, wb_offset1,
           wb_vd, misaligned
  );
endinterface

// File: rtl/rv32v_mem_lane_serializer.sv
// Two-lane vector memory stage: latches one execute beat, issues one
// data-memory transaction per active lane (lane 0 first), then presents a
// single-cycle writeback beat. Non-memory beats pass straight to writeback.
// All memory and writeback outputs are decoded from latched state only.
module rv32v_mem_lane_serializer #(
  parameter int OFFSET_W = 5
) (
  input  logic CLK,
  input  logic nRST,
  rv32v_mem_lane_serializer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ0, REQ1, RESP} state_t;

  state_t              state_reg;
  state_t              state_next;

  logic                is_load_reg;
  logic                is_store_reg;
  logic [1:0]          lane_en_reg;   // original lane mask, steers REQ0 -> REQ1
  logic [1:0]          wb_mask_reg;   // writeback enables, cleared per misaligned lane
  logic [1:0]          eew_reg;
  logic [31:0]         addr_reg   [2];
  logic [31:0]         sdata_reg  [2];
  logic [31:0]         result_reg [2];
  logic [OFFSET_W-1:0] offset_reg [2];
  logic [4:0]          vd_reg;
  logic                mis_reg;

  logic                accept;
  logic                mem_beat;
  logic [1:0]          lane_mis;
  logic                in_req;
  logic                cur;
  logic [31:0]         cur_addr;
  logic [31:0]         cur_sdata;
  logic                req_live;
  logic                req_done;
  logic [3:0]          byte_en;
  logic [31:0]         wdata;
  logic [31:0]         rshift8;
  logic [31:0]         rshift16;
  logic [31:0]         load_elem;
  logic                resp;

  assign accept   = (state_reg == IDLE) && bus.ena;
  assign mem_beat = bus.load_ena || bus.store_ena;

  // Per-lane alignment check against the latched element width (3 acts as 32b).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_mis[gi] = (eew_reg == 2'd0) ? 1'b0 :
                            (eew_reg == 2'd1) ? addr_reg[gi][0] :
                                                (|addr_reg[gi][1:0]);
    end
  endgenerate

  assign in_req    = (state_reg == REQ0) || (state_reg == REQ1);
  assign cur       = (state_reg == REQ1);
  assign cur_addr  = addr_reg[cur];
  assign cur_sdata = sdata_reg[cur];
  // A misaligned lane never reaches the memory and finishes in one cycle.
  assign req_live  = in_req && !lane_mis[cur];
  assign req_done  = in_req && (lane_mis[cur] || !bus.dmem_busy);

  // Byte-lane steering, store replication and load element extraction.
  always_comb begin
    byte_en   = 4'b1111;
    wdata     = cur_sdata;
    rshift8   = bus.dmem_rdata >> {cur_addr[1:0], 3'b000};
    rshift16  = bus.dmem_rdata >> {cur_addr[1], 4'b0000};
    load_elem = bus.dmem_rdata;
    case (eew_reg)
      2'd0: begin
        byte_en   = 4'b0001 << cur_addr[1:0];
        wdata     = {4{cur_sdata[7:0]}};
        load_elem = {24'd0, rshift8[7:0]};
      end
      2'd1: begin
        byte_en   = 4'b0011 << {cur_addr[1], 1'b0};
        wdata     = {2{cur_sdata[15:0]}};
        load_elem = {16'd0, rshift16[15:0]};
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode: lane 0 before lane 1, skipping inactive lanes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.ena) begin
          if (mem_beat && (bus.wen != 2'b00))
            state_next = bus.wen[0] ? REQ0 : REQ1;
          else
            state_next = RESP;
        end
      end
      REQ0: if (req_done) state_next = lane_en_reg[1] ? REQ1 : RESP;
      REQ1: if (req_done) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat capture on accept, per-lane load capture / misalignment marking.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      is_load_reg   <= 1'b0;
      is_store_reg  <= 1'b0;
      lane_en_reg   <= 2'b00;
      wb_mask_reg   <= 2'b00;
      eew_reg       <= 2'd0;
      addr_reg[0]   <= '0;
      addr_reg[1]   <= '0;
      sdata_reg[0]  <= '0;
      sdata_reg[1]  <= '0;
      result_reg[0] <= '0;
      result_reg[1] <= '0;
      offset_reg[0] <= '0;
      offset_reg[1] <= '0;
      vd_reg        <= '0;
      mis_reg       <= 1'b0;
    end else if (accept) begin
      is_load_reg   <= bus.load_ena;
      is_store_reg  <= bus.store_ena;
      lane_en_reg   <= bus.wen;
      // Stores never write the register file.
      wb_mask_reg   <= bus.store_ena ? 2'b00 : bus.wen;
      eew_reg       <= bus.eew;
      addr_reg[0]   <= bus.aluresult0;
      addr_reg[1]   <= bus.aluresult1;
      sdata_reg[0]  <= bus.storedata0;
      sdata_reg[1]  <= bus.storedata1;
      result_reg[0] <= bus.aluresult0;
      result_reg[1] <= bus.aluresult1;
      offset_reg[0] <= bus.woffset0;
      offset_reg[1] <= bus.woffset1;
      vd_reg        <= bus.vd;
      mis_reg       <= 1'b0;
    end else if (req_done) begin
      if (lane_mis[cur]) begin
        wb_mask_reg[cur] <= 1'b0;
        mis_reg          <= 1'b1;
      end else if (is_load_reg) begin
        result_reg[cur]  <= load_elem;
      end
    end else if (state_reg == RESP) begin
      mis_reg <= 1'b0;
    end
  end

  assign resp = (state_reg == RESP);

  assign bus.stall        = (state_reg != IDLE);
  assign bus.dmem_addr    = req_live ? {cur_addr[31:2], 2'b00} : 32'd0;
  assign bus.dmem_ren     = req_live && is_load_reg;
  assign bus.dmem_wen     = req_live && is_store_reg;
  assign bus.dmem_byte_en = req_live ? byte_en : 4'b0000;
  assign bus.dmem_wdata   = (req_live && is_store_reg) ? wdata : 32'd0;

  assign bus.wb_valid     = resp;
  assign bus.wb_wen       = resp ? wb_mask_reg : 2'b00;
  assign bus.wb_data0     = resp ? result_reg[0] : 32'd0;
  assign bus.wb_data1     = resp ? result_reg[1] : 32'd0;
  assign bus.wb_offset0   = resp ? offset_reg[0] : '0;
  assign bus.wb_offset1   = resp ? offset_reg[1] : '0;
  assign bus.wb_vd        = resp ? vd_reg : 5'd0;
  assign bus.misaligned   = resp && mis_reg;

endmodule

// File: tb/tb_rv32v_mem_lane_serializer.sv
// Directed bench for the two-lane vector memory serializer. Each scenario
// drives one beat on a falling edge, then checks outputs cycle by cycle on
// later falling edges against hand-computed values.
module tb_rv32v_mem_lane_serializer;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;

  rv32v_mem_lane_serializer_if #(.OFFSET_W(5)) bus ();

  rv32v_mem_lane_serializer #(.OFFSET_W(5)) dut (
    .CLK  (clk),
    .nRST (n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ena        = 1'b0;
    bus.load_ena   = 1'b0;
    bus.store_ena  = 1'b0;
    bus.wen        = 2'b00;
    bus.aluresult0 = 32'd0;
    bus.aluresult1 = 32'd0;
    bus.storedata0 = 32'd0;
    bus.storedata1 = 32'd0;
    bus.eew        = 2'd0;
    bus.vd         = 5'd0;
    bus.woffset0   = 5'd0;
    bus.woffset1   = 5'd0;
    bus.dmem_rdata = 32'd0;
    bus.dmem_busy  = 1'b0;
  endtask

  // Presents a beat for one cycle (cycle 0) and returns at the falling edge
  // of cycle 1 with ena already dropped.
  task automatic send_beat(input logic ld, input logic st, input logic [1:0] wen,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [1:0] eew, input logic [4:0] vd,
                           input logic [4:0] o0, input logic [4:0] o1);
    @(negedge clk);
    bus.ena        = 1'b1;
    bus.load_ena   = ld;
    bus.store_ena  = st;
    bus.wen        = wen;
    bus.aluresult0 = a0;
    bus.aluresult1 = a1;
    bus.storedata0 = d0;
    bus.storedata1 = d1;
    bus.eew        = eew;
    bus.vd         = vd;
    bus.woffset0   = o0;
    bus.woffset1   = o1;
    @(negedge clk);
    bus.ena        = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},  {31'd0, bus.stall}, 32'd0);
    check({tag, "_ren"},    {31'd0, bus.dmem_ren}, 32'd0);
    check({tag, "_dwen"},   {31'd0, bus.dmem_wen}, 32'd0);
    check({tag, "_addr"},   bus.dmem_addr, 32'd0);
    check({tag, "_wdata"},  bus.dmem_wdata, 32'd0);
    check({tag, "_be"},     {28'd0, bus.dmem_byte_en}, 32'd0);
    check({tag, "_wbv"},    {31'd0, bus.wb_valid}, 32'd0);
    check({tag, "_wbwen"},  {30'd0, bus.wb_wen}, 32'd0);
    check({tag, "_wbd0"},   bus.wb_data0, 32'd0);
    check({tag, "_wbd1"},   bus.wb_data1, 32'd0);
    check({tag, "_wbo"},    {22'd0, bus.wb_offset1, bus.wb_offset0}, 32'd0);
    check({tag, "_wbvd"},   {27'd0, bus.wb_vd}, 32'd0);
    check({tag, "_mis"},    {31'd0, bus.misaligned}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_rst = 1'b1;

    // Word load, both lanes, no wait states.
    send_beat(1'b1, 1'b0, 2'b11, 32'h100, 32'h104, 32'd0, 32'd0, 2'd2, 5'd3, 5'd4, 5'd5);
    bus.dmem_rdata = 32'hDEADBEEF;
    check("wl_c1_ren",   {31'd0, bus.dmem_ren}, 32'd1);
    check("wl_c1_addr",  bus.dmem_addr, 32'h100);
    check("wl_c1_be",    {28'd0, bus.dmem_byte_en}, 32'hF);
    check("wl_c1_stall", {31'd0, bus.stall}, 32'd1);
    check("wl_c1_wbv",   {31'd0, bus.wb_valid}, 32'd0);
    @(negedge clk);
    bus.dmem_rdata = 32'h12345678;
    check("wl_c2_ren",   {31'd0, bus.dmem_ren}, 32'd1);
    check("wl_c2_addr",  bus.dmem_addr, 32'h104);
    check("wl_c2_wbv",   {31'd0, bus.wb_valid}, 32'd0);
    @(negedge clk);
    check("wl_c3_wbv",   {31'd0, bus.wb_valid}, 32'd1);
    check("wl_c3_wbwen", {30'd0, bus.wb_wen}, 32'd3);
    check("wl_c3_d0",    bus.wb_data0, 32'hDEADBEEF);
    check("wl_c3_d1",    bus.wb_data1, 32'h12345678);
    check("wl_c3_vd",    {27'd0, bus.wb_vd}, 32'd3);
    check("wl_c3_off",   {22'd0, bus.wb_offset1, bus.wb_offset0}, {22'd0, 5'd5, 5'd4});
    check("wl_c3_mis",   {31'd0, bus.misaligned}, 32'd0);
    check("wl_c3_ren",   {31'd0, bus.dmem_ren}, 32'd0);
    @(negedge clk);
    check("wl_c4_wbv",   {31'd0, bus.wb_valid}, 32'd0);
    check("wl_c4_stall", {31'd0, bus.stall}, 32'd0);
    $display("txn word_load_both checks=%0d failures=%0d", checks, failures);

    // Byte store, lane 1 only.
    send_beat(1'b0, 1'b1, 2'b10, 32'h0, 32'h203, 32'h0, 32'hAB, 2'd0, 5'd1, 5'd0, 5'd0);
    check("bs_c1_dwen",  {31'd0, bus.dmem_wen}, 32'd1);
    check("bs_c1_ren",   {31'd0, bus.dmem_ren}, 32'd0);
    check("bs_c1_addr",  bus.dmem_addr, 32'h200);
    check("bs_c1_be",    {28'd0, bus.dmem_byte_en}, 32'h8);
    check("bs_c1_wdata", bus.dmem_wdata, 32'hABABABAB);
    @(negedge clk);
    check("bs_c2_wbv",   {31'd0, bus.wb_valid}, 32'd1);
    check("bs_c2_wbwen", {30'd0, bus.wb_wen}, 32'd0);
    check("bs_c2_dwen",  {31'd0, bus.dmem_wen}, 32'd0);
    $display("txn byte_store_lane1 checks=%0d failures=%0d", checks, failures);

    // Halfword load lane 0 with three busy cycles.
    send_beat(1'b1, 1'b0, 2'b01, 32'h302, 32'h0, 32'd0, 32'd0, 2'd1, 5'd7, 5'd2, 5'd0);
    for (int c = 1; c <= 4; c++) begin
      bus.dmem_busy  = (c < 4);
      bus.dmem_rdata = (c < 4) ? 32'h0 : 32'hCAFE1234;
      check($sformatf("hl_c%0d_ren", c),  {31'd0, bus.dmem_ren}, 32'd1);
      check($sformatf("hl_c%0d_addr", c), bus.dmem_addr, 32'h300);
      check($sformatf("hl_c%0d_be", c),   {28'd0, bus.dmem_byte_en}, 32'hC);
      check($sformatf("hl_c%0d_wbv", c),  {31'd0, bus.wb_valid}, 32'd0);
      @(negedge clk);
    end
    bus.dmem_busy = 1'b0;
    check("hl_c5_wbv",   {31'd0, bus.wb_valid}, 32'd1);
    check("hl_c5_d0",    bus.wb_data0, 32'h0000CAFE);
    check("hl_c5_wbwen", {30'd0, bus.wb_wen}, 32'd1);
    $display("txn half_load_busy checks=%0d failures=%0d", checks, failures);

    // Word load with lane 0 misaligned.
    send_beat(1'b1, 1'b0, 2'b11, 32'h401, 32'h404, 32'd0, 32'd0, 2'd2, 5'd8, 5'd0, 5'd1);
    check("mis_c1_ren",  {31'd0, bus.dmem_ren}, 32'd0);
    check("mis_c1_addr", bus.dmem_addr, 32'd0);
    check("mis_c1_stall", {31'd0, bus.stall}, 32'd1);
    @(negedge clk);
    bus.dmem_rdata = 32'h55AA55AA;
    check("mis_c2_ren",  {31'd0, bus.dmem_ren}, 32'd1);
    check("mis_c2_addr", bus.dmem_addr, 32'h404);
    @(negedge clk);
    check("mis_c3_wbv",   {31'd0, bus.wb_valid}, 32'd1);
    check("mis_c3_wbwen", {30'd0, bus.wb_wen}, 32'd2);
    check("mis_c3_mis",   {31'd0, bus.misaligned}, 32'd1);
    check("mis_c3_d1",    bus.wb_data1, 32'h55AA55AA);
    @(negedge clk);
    check("mis_c4_mis",   {31'd0, bus.misaligned}, 32'd0);
    $display("txn misaligned_lane0 checks=%0d failures=%0d", checks, failures);

    // Non-memory pass-through.
    send_beat(1'b0, 1'b0, 2'b11, 32'd5, 32'd7, 32'd0, 32'd0, 2'd2, 5'd9, 5'd0, 5'd0);
    check("pt_c1_wbv",   {31'd0, bus.wb_valid}, 32'd1);
    check("pt_c1_d0",    bus.wb_data0, 32'd5);
    check("pt_c1_d1",    bus.wb_data1, 32'd7);
    check("pt_c1_wbwen", {30'd0, bus.wb_wen}, 32'd3);
    check("pt_c1_req",   {30'd0, bus.dmem_ren, bus.dmem_wen}, 32'd0);
    @(negedge clk);
    check("pt_c2_wbv",   {31'd0, bus.wb_valid}, 32'd0);
    $display("txn pass_through checks=%0d failures=%0d", checks, failures);

    // Byte load lane 1 and halfword store lane 0 exercise the other steering.
    send_beat(1'b1, 1'b0, 2'b10, 32'h0, 32'h702, 32'd0, 32'd0, 2'd0, 5'd2, 5'd0, 5'd0);
    bus.dmem_rdata = 32'h11223344;
    check("bl_c1_be",  {28'd0, bus.dmem_byte_en}, 32'h4);
    @(negedge clk);
    check("bl_c2_d1",  bus.wb_data1, 32'h00000022);
    send_beat(1'b0, 1'b1, 2'b01, 32'h802, 32'h0, 32'h1234ABCD, 32'd0, 2'd1, 5'd0, 5'd0, 5'd0);
    check("hs_c1_be",    {28'd0, bus.dmem_byte_en}, 32'hC);
    check("hs_c1_wdata", bus.dmem_wdata, 32'hABCDABCD);
    check("hs_c1_addr",  bus.dmem_addr, 32'h800);
    @(negedge clk);
    $display("txn byte_load_half_store checks=%0d failures=%0d", checks, failures);

    // Reset asserted during REQ1 with memory busy.
    send_beat(1'b1, 1'b0, 2'b11, 32'h500, 32'h504, 32'd0, 32'd0, 2'd2, 5'd4, 5'd1, 5'd1);
    bus.dmem_rdata = 32'h99999999;
    @(negedge clk);
    bus.dmem_busy = 1'b1;
    check("rst_c2_ren",  {31'd0, bus.dmem_ren}, 32'd1);
    check("rst_c2_addr", bus.dmem_addr, 32'h504);
    #2;
    n_rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    check("rst_after_wbv",   {31'd0, bus.wb_valid}, 32'd0);
    check("rst_after_stall", {31'd0, bus.stall}, 32'd0);
    n_rst = 1'b1;
    bus.dmem_busy = 1'b0;
    send_beat(1'b1, 1'b0, 2'b01, 32'h600, 32'h0, 32'd0, 32'd0, 2'd2, 5'd6, 5'd0, 5'd0);
    bus.dmem_rdata = 32'h0BADF00D;
    check("fresh_c1_addr", bus.dmem_addr, 32'h600);
    @(negedge clk);
    check("fresh_c2_wbv", {31'd0, bus.wb_valid}, 32'd1);
    check("fresh_c2_d0",  bus.wb_data0, 32'h0BADF00D);
    check("fresh_c2_vd",  {27'd0, bus.wb_vd}, 32'd6);
    $display("txn reset_mid_req1 checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
